aes_block_loader: RTL and testbench

- Payload loader directly downstream of the command decoder in the UART-to-AES path.
- After the decoder accepts an 'A' (key) or 'B' (data) command, collects the following NUM_BYTES received bytes into a 128-bit shadow register.
- On completion, publishes the result atomically as Key or DataIn, with a one-cycle valid pulse to the AES core.

---
 rtl/aes_block_loader.sv | 146 ++++++++++++++
 tb/tb_aes_block_loader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_block_loader.sv
// Payload loader between the UART command decoder and the AES core: shifts NUM_BYTES
// bytes into a shadow register and publishes them atomically as Key or DataIn.
// Optional inter-byte gap watchdog enabled by defining LOADER_TIMEOUT_EN.
module aes_block_loader #(
  parameter int NUM_BYTES      = 16,
  parameter int CNT_W          = 5,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [7:0]             RxByte,
  input  logic                   RxByteValid,
  input  logic                   StartKey,
  input  logic                   StartData,
  output logic [8*NUM_BYTES-1:0] Key,
  output logic [8*NUM_BYTES-1:0] DataIn,
  output logic                   KeyValid,
  output logic                   DataValid,
  output logic                   Busy,
  output logic [CNT_W-1:0]       ByteCount,
  output logic                   Timeout
);

  localparam int BLK_W = 8 * NUM_BYTES;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_KEY,
    LOAD_DATA
  } state_t;

  state_t             r_state,     w_stateNext;
  logic [BLK_W-1:0]   r_shadow,    w_shadowNext;
  logic [BLK_W-1:0]   r_key,       w_keyNext;
  logic [BLK_W-1:0]   r_data,      w_dataNext;
  logic [CNT_W-1:0]   r_count,     w_countNext;
  logic               r_keyValid,  w_keyValidNext;
  logic               r_dataValid, w_dataValidNext;
  logic               r_busy;
  logic               r_timeout,   w_timeoutNext;
  logic [BLK_W-1:0]   w_shifted;

  // First byte received ends up in the most significant byte.
  assign w_shifted = {r_shadow[BLK_W-9:0], RxByte};

`ifdef LOADER_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [GAP_W-1:0] r_gap, w_gapNext;
`else
  logic w_unusedTimeoutCycles;
  assign w_unusedTimeoutCycles = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state     <= IDLE;
      r_shadow    <= '0;
      r_key       <= '0;
      r_data      <= '0;
      r_count     <= '0;
      r_keyValid  <= 1'b0;
      r_dataValid <= 1'b0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_shadow    <= w_shadowNext;
      r_key       <= w_keyNext;
      r_data      <= w_dataNext;
      r_count     <= w_countNext;
      r_keyValid  <= w_keyValidNext;
      r_dataValid <= w_dataValidNext;
      r_busy      <= (w_stateNext != IDLE);
      r_timeout   <= w_timeoutNext;
    end
  end

`ifdef LOADER_TIMEOUT_EN
  always_ff @(posedge Clk) begin
    if (Rst) r_gap <= '0;
    else     r_gap <= w_gapNext;
  end
`endif

  always_comb begin
    w_stateNext     = r_state;
    w_shadowNext    = r_shadow;
    w_keyNext       = r_key;
    w_dataNext      = r_data;
    w_countNext     = r_count;
    w_keyValidNext  = 1'b0;
    w_dataValidNext = 1'b0;
    w_timeoutNext   = 1'b0;
`ifdef LOADER_TIMEOUT_EN
    w_gapNext       = '0;
`endif
    case (r_state)
      IDLE: begin
        // Count may still read NUM_BYTES during the valid-pulse cycle; clear it here.
        w_countNext = '0;
        if (StartKey)       w_stateNext = LOAD_KEY;
        else if (StartData) w_stateNext = LOAD_DATA;
      end
      LOAD_KEY, LOAD_DATA: begin
        if (StartKey || StartData) begin
          // A start pulse alongside a byte marks that byte as the command, not payload.
          w_countNext = '0;
          w_stateNext = StartKey ? LOAD_KEY : LOAD_DATA;
        end else if (RxByteValid) begin
          w_shadowNext = w_shifted;
          w_countNext  = r_count + 1'b1;
          if (r_count == CNT_W'(NUM_BYTES - 1)) begin
            w_stateNext = IDLE;
            if (r_state == LOAD_KEY) begin
              w_keyNext      = w_shifted;
              w_keyValidNext = 1'b1;
            end else begin
              w_dataNext      = w_shifted;
              w_dataValidNext = 1'b1;
            end
          end
        end else begin
`ifdef LOADER_TIMEOUT_EN
          if (r_gap == GAP_W'(TIMEOUT_CYCLES - 1)) begin
            w_stateNext   = IDLE;
            w_countNext   = '0;
            w_timeoutNext = 1'b1;
          end else begin
            w_gapNext = r_gap + 1'b1;
          end
`endif
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  assign Key       = r_key;
  assign DataIn    = r_data;
  assign KeyValid  = r_keyValid;
  assign DataValid = r_dataValid;
  assign Busy      = r_busy;
  assign ByteCount = r_count;
  assign Timeout   = r_timeout;

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed self-checking bench for aes_block_loader in its default build
// (LOADER_TIMEOUT_EN undefined, NUM_BYTES = 16).
module tb_aes_block_loader;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic [7:0]   RxByte = 8'h00;
  logic         RxByteValid = 1'b0;
  logic         StartKey = 1'b0;
  logic         StartData = 1'b0;
  logic [127:0] Key;
  logic [127:0] DataIn;
  logic         KeyValid;
  logic         DataValid;
  logic         Busy;
  logic [4:0]   ByteCount;
  logic         Timeout;

  int vectors = 0;
  int miscompares = 0;
  int keyPulses = 0;
  int dataPulses = 0;
  int timeoutPulses = 0;

  localparam logic [127:0] KEY1  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] DATA1 = 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0;
  localparam logic [127:0] DATAA = {16{8'hAA}};
  localparam logic [127:0] KEY2  = 128'h202122232425262728292A2B2C2D2E2F;
  localparam logic [127:0] KEY3  = 128'h808182838485868788898A8B8C8D8E8F;
  localparam logic [127:0] DATA4 = 128'hC0C1000102030405060708090A0B0C0D;

  aes_block_loader dut (
    .Clk(Clk), .Rst(Rst), .RxByte(RxByte), .RxByteValid(RxByteValid),
    .StartKey(StartKey), .StartData(StartData), .Key(Key), .DataIn(DataIn),
    .KeyValid(KeyValid), .DataValid(DataValid), .Busy(Busy),
    .ByteCount(ByteCount), .Timeout(Timeout)
  );

  always #5 Clk = ~Clk;

  // Pulse counters observe the value held during the cycle preceding each edge.
  always @(posedge Clk) begin
    if (KeyValid)  keyPulses     <= keyPulses + 1;
    if (DataValid) dataPulses    <= dataPulses + 1;
    if (Timeout)   timeoutPulses <= timeoutPulses + 1;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulseStart(input logic isKey, input logic isData);
    StartKey  = isKey;
    StartData = isData;
    tick();
    StartKey  = 1'b0;
    StartData = 1'b0;
  endtask

  // Sends count bytes first, first+step, ...; gap idle clocks between bytes only.
  task automatic sendBytes(input logic [7:0] first, input int step, input int count, input int gap);
    logic [7:0] b;
    b = first;
    for (int i = 0; i < count; i++) begin
      RxByte      = b;
      RxByteValid = 1'b1;
      tick();
      RxByteValid = 1'b0;
      b = b + 8'(step);
      if (i != count - 1) repeat (gap) tick();
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    tick();
    tick();
    Rst = 1'b0;
    vectors++;
    if ({Key, DataIn} !== 256'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_regs: Key=%h DataIn=%h, want 0", Key, DataIn);
    end
    vectors++;
    if ({KeyValid, DataValid, Busy, ByteCount, Timeout} !== 9'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: kv=%b dv=%b busy=%b cnt=%0d to=%b, want all 0",
               KeyValid, DataValid, Busy, ByteCount, Timeout);
    end
  endtask

  task automatic test_key_load();
    int kp;
    kp = keyPulses;
    pulseStart(1'b1, 1'b0);
    vectors++;
    if (Busy !== 1'b1 || ByteCount !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL key_start: busy=%b cnt=%0d, want 1/0", Busy, ByteCount);
    end
    sendBytes(8'h00, 1, 15, 3);
    repeat (3) tick();
    vectors++;
    if (ByteCount !== 5'd15 || KeyValid !== 1'b0 || Key !== 128'd0) begin
      miscompares++;
      $display("[TB] FAIL key_partial: cnt=%0d kv=%b Key=%h, want 15/0/0", ByteCount, KeyValid, Key);
    end
    sendBytes(8'h0F, 1, 1, 0);
    vectors++;
    if (Key !== KEY1 || KeyValid !== 1'b1 || Busy !== 1'b0 || ByteCount !== 5'd16) begin
      miscompares++;
      $display("[TB] FAIL key_done: Key=%h kv=%b busy=%b cnt=%0d, want %h/1/0/16",
               Key, KeyValid, Busy, ByteCount, KEY1);
    end
    vectors++;
    if (DataIn !== 128'd0 || DataValid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL key_data_untouched: DataIn=%h dv=%b, want 0/0", DataIn, DataValid);
    end
    tick();
    vectors++;
    if (KeyValid !== 1'b0 || ByteCount !== 5'd0 || keyPulses - kp !== 1) begin
      miscompares++;
      $display("[TB] FAIL key_pulse: kv=%b cnt=%0d pulses=%0d, want 0/0/1", KeyValid, ByteCount, keyPulses - kp);
    end
  endtask

  task automatic test_data_load();
    int dp;
    dp = dataPulses;
    pulseStart(1'b0, 1'b1);
    sendBytes(8'hFF, -1, 16, 0);
    vectors++;
    if (DataIn !== DATA1 || DataValid !== 1'b1 || KeyValid !== 1'b0 || Key !== KEY1) begin
      miscompares++;
      $display("[TB] FAIL data_done: DataIn=%h dv=%b kv=%b Key=%h, want %h/1/0/%h",
               DataIn, DataValid, KeyValid, Key, DATA1, KEY1);
    end
    tick();
    vectors++;
    if (DataValid !== 1'b0 || Busy !== 1'b0 || dataPulses - dp !== 1) begin
      miscompares++;
      $display("[TB] FAIL data_pulse: dv=%b busy=%b pulses=%0d, want 0/0/1", DataValid, Busy, dataPulses - dp);
    end
  endtask

  task automatic test_restart();
    int kp;
    kp = keyPulses;
    pulseStart(1'b1, 1'b0);
    sendBytes(8'h11, 1, 5, 0);
    vectors++;
    if (ByteCount !== 5'd5) begin
      miscompares++;
      $display("[TB] FAIL restart_partial: cnt=%0d, want 5", ByteCount);
    end
    pulseStart(1'b0, 1'b1);
    vectors++;
    if (ByteCount !== 5'd0 || Busy !== 1'b1 || Key !== KEY1 || DataIn !== DATA1) begin
      miscompares++;
      $display("[TB] FAIL restart_cleared: cnt=%0d busy=%b Key=%h DataIn=%h", ByteCount, Busy, Key, DataIn);
    end
    sendBytes(8'hAA, 0, 16, 0);
    vectors++;
    if (DataIn !== DATAA || DataValid !== 1'b1 || ByteCount !== 5'd16 || Key !== KEY1) begin
      miscompares++;
      $display("[TB] FAIL restart_done: DataIn=%h dv=%b cnt=%0d Key=%h, want %h/1/16/%h",
               DataIn, DataValid, ByteCount, Key, DATAA, KEY1);
    end
    tick();
    vectors++;
    if (ByteCount !== 5'd0 || keyPulses != kp) begin
      miscompares++;
      $display("[TB] FAIL restart_after: cnt=%0d keyPulses=%0d, want 0/0", ByteCount, keyPulses - kp);
    end
  endtask

  task automatic test_simultaneous();
    RxByte      = 8'h41;
    RxByteValid = 1'b1;
    pulseStart(1'b1, 1'b1);
    RxByteValid = 1'b0;
    vectors++;
    if (ByteCount !== 5'd0 || Busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL simul_start: cnt=%0d busy=%b, want 0/1", ByteCount, Busy);
    end
    sendBytes(8'h20, 1, 16, 1);
    vectors++;
    if (Key !== KEY2 || KeyValid !== 1'b1 || DataValid !== 1'b0 || DataIn !== DATAA) begin
      miscompares++;
      $display("[TB] FAIL simul_key_wins: Key=%h kv=%b dv=%b DataIn=%h, want %h/1/0/%h",
               Key, KeyValid, DataValid, DataIn, KEY2, DATAA);
    end
    tick();
    // Restart mid-load with a byte present: that byte is the command, not payload.
    pulseStart(1'b1, 1'b0);
    sendBytes(8'h01, 1, 3, 0);
    RxByte      = 8'h55;
    RxByteValid = 1'b1;
    pulseStart(1'b0, 1'b1);
    RxByteValid = 1'b0;
    vectors++;
    if (ByteCount !== 5'd0 || Key !== KEY2) begin
      miscompares++;
      $display("[TB] FAIL restart_with_byte: cnt=%0d Key=%h, want 0/%h", ByteCount, Key, KEY2);
    end
    // Default build: no watchdog, so a long gap just waits.
    sendBytes(8'hC0, 1, 2, 0);
    repeat (50) tick();
    vectors++;
    if (Busy !== 1'b1 || ByteCount !== 5'd2 || timeoutPulses != 0 || Timeout !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL no_timeout: busy=%b cnt=%0d toPulses=%0d, want 1/2/0", Busy, ByteCount, timeoutPulses);
    end
    sendBytes(8'h00, 1, 14, 0);
    vectors++;
    if (DataIn !== DATA4 || DataValid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL gap_data_done: DataIn=%h dv=%b, want %h/1", DataIn, DataValid, DATA4);
    end
    tick();
  endtask

  task automatic test_reset_mid_load();
    pulseStart(1'b1, 1'b0);
    sendBytes(8'h01, 1, 8, 0);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    vectors++;
    if ({Key, DataIn} !== 256'd0 || {KeyValid, DataValid, Busy, ByteCount, Timeout} !== 9'd0) begin
      miscompares++;
      $display("[TB] FAIL midload_reset: Key=%h DataIn=%h busy=%b cnt=%0d, want all 0", Key, DataIn, Busy, ByteCount);
    end
    pulseStart(1'b1, 1'b0);
    sendBytes(8'h80, 1, 16, 2);
    vectors++;
    if (Key !== KEY3 || KeyValid !== 1'b1 || DataIn !== 128'd0) begin
      miscompares++;
      $display("[TB] FAIL post_reset_key: Key=%h kv=%b DataIn=%h, want %h/1/0", Key, KeyValid, DataIn, KEY3);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_key_load();
    test_data_load();
    test_restart();
    test_simultaneous();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
